// File: rtl/regfile_sb_pkg.sv
// Shared sizing for the decode stage and the register file, so both sides
// agree on word width, register-name width and register count.
package regfile_sb_pkg;

    // Default data word width.
    localparam int W_WORD_DFLT = 16;
    // Default register name width.
    localparam int W_RD_DFLT   = 3;
    // Default register count; always 2**W_RD so every name is a real register.
    localparam int NREG_DFLT   = 8;

    // Width of a busy counter able to hold 0..nreg inclusive.
    function automatic int cnt_width(input int w_rd);
        return w_rd + 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Reservation scoreboard: one pending-write bit per register, a busy counter
// that tracks the number of set bits, and a sticky protocol-error flag.
// Reserve beats a same-edge writeback to the same register.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int W_RD = W_RD_DFLT,
    parameter int NREG = NREG_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_RD-1:0] rsv_name,
    input  logic            rsv_req,
    input  logic            wb_we,
    input  logic [W_RD-1:0] wb_name,
    output logic [NREG-1:0] rsv_vec,
    output logic [W_RD:0]   busy_cnt,
    output logic            err
);

    logic [NREG-1:0] rsv_r;
    logic [NREG-1:0] rsv_nxt_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic [W_RD:0]   cnt_r;
    logic [W_RD:0]   cnt_nxt_s;
    logic            err_r;
    logic            same_s;
    logic            inc_s;
    logic            dec_s;
    logic            viol_a_s;
    logic            viol_b_s;

    // Next reservation vector, counter delta and protocol-violation detection.
    always_comb begin
        same_s     = wb_we && (wb_name == rsv_name);
        set_mask_s = {NREG{rsv_req}} & ({{(NREG-1){1'b0}}, 1'b1} << rsv_name);
        clr_mask_s = {NREG{wb_we}}   & ({{(NREG-1){1'b0}}, 1'b1} << wb_name);
        // Set is applied after clear so a same-register reserve wins.
        rsv_nxt_s  = (rsv_r & ~clr_mask_s) | set_mask_s;
        inc_s      = rsv_req && !rsv_r[rsv_name];
        // A writeback that a same-edge reserve immediately re-arms frees nothing.
        dec_s      = wb_we && rsv_r[wb_name] && !(rsv_req && same_s);
        viol_a_s   = rsv_req && rsv_r[rsv_name] && !same_s;
        viol_b_s   = wb_we && !rsv_r[wb_name];
        case ({inc_s, dec_s})
            2'b10:   cnt_nxt_s = cnt_r + {{W_RD{1'b0}}, 1'b1};
            2'b01:   cnt_nxt_s = cnt_r - {{W_RD{1'b0}}, 1'b1};
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Scoreboard state; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsv_r <= {NREG{1'b0}};
            cnt_r <= {(W_RD+1){1'b0}};
            err_r <= 1'b0;
        end else begin
            rsv_r <= rsv_nxt_s;
            cnt_r <= cnt_nxt_s;
            err_r <= err_r | viol_a_s | viol_b_s;
        end
    end

    assign rsv_vec  = rsv_r;
    assign busy_cnt = cnt_r;
    assign err      = err_r;

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with per-register reservation scoreboard,
// serving the decode stage's register interface. Reads are combinational.
// Optional macro REGFILE_WB_BYPASS_EN forwards a same-cycle writeback onto
// the read ports and shows the register as no longer reserved.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int W_WORD = W_WORD_DFLT,
    parameter int W_RD   = W_RD_DFLT,
    parameter int NREG   = NREG_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_RD-1:0]   rd_name_i,
    input  logic [W_RD-1:0]   rs_name_i,
    input  logic              rd_reserve_i,
    output logic [W_WORD-1:0] rd_data_o,
    output logic [W_WORD-1:0] rs_data_o,
    output logic              rd_reserved_o,
    output logic              rs_reserved_o,
    input  logic              wb_we_i,
    input  logic [W_RD-1:0]   wb_name_i,
    input  logic [W_WORD-1:0] wb_data_i,
    output logic [W_RD:0]     busy_cnt_o,
    output logic              err_o
);

    logic [W_WORD-1:0] mem_r [NREG];
    logic [NREG-1:0]   rsv_s;

    regfile_scoreboard #(
        .W_RD (W_RD),
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_name (rd_name_i),
        .rsv_req  (rd_reserve_i),
        .wb_we    (wb_we_i),
        .wb_name  (wb_name_i),
        .rsv_vec  (rsv_s),
        .busy_cnt (busy_cnt_o),
        .err      (err_o)
    );

    // Data array: writeback stores unconditionally, even when flagged as a violation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {W_WORD{1'b0}};
            end
        end else if (wb_we_i) begin
            mem_r[wb_name_i] <= wb_data_i;
        end
    end

    // Read muxes for the two decode ports, with optional writeback forwarding.
    always_comb begin
        rd_data_o     = mem_r[rd_name_i];
        rs_data_o     = mem_r[rs_name_i];
        rd_reserved_o = rsv_s[rd_name_i];
        rs_reserved_o = rsv_s[rs_name_i];
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_we_i && (wb_name_i == rd_name_i)) begin
            rd_data_o     = wb_data_i;
            rd_reserved_o = 1'b0;
        end else begin
            rd_data_o     = mem_r[rd_name_i];
            rd_reserved_o = rsv_s[rd_name_i];
        end
        if (wb_we_i && (wb_name_i == rs_name_i)) begin
            rs_data_o     = wb_data_i;
            rs_reserved_o = 1'b0;
        end else begin
            rs_data_o     = mem_r[rs_name_i];
            rs_reserved_o = rsv_s[rs_name_i];
        end
`else
        if (wb_we_i) begin
            // Stored state only; the new value appears after the edge.
            rd_data_o = mem_r[rd_name_i];
        end else begin
            rd_data_o = mem_r[rd_name_i];
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb. Honors REGFILE_WB_BYPASS_EN.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [2:0]  rd_name_i;
    logic [2:0]  rs_name_i;
    logic        rd_reserve_i;
    logic [15:0] rd_data_o;
    logic [15:0] rs_data_o;
    logic        rd_reserved_o;
    logic        rs_reserved_o;
    logic        wb_we_i;
    logic [2:0]  wb_name_i;
    logic [15:0] wb_data_i;
    logic [3:0]  busy_cnt_o;
    logic        err_o;

    int checks;
    int errors;

    regfile_sb dut (
        .clk           (clk),
        .rst           (rst),
        .rd_name_i     (rd_name_i),
        .rs_name_i     (rs_name_i),
        .rd_reserve_i  (rd_reserve_i),
        .rd_data_o     (rd_data_o),
        .rs_data_o     (rs_data_o),
        .rd_reserved_o (rd_reserved_o),
        .rs_reserved_o (rs_reserved_o),
        .wb_we_i       (wb_we_i),
        .wb_name_i     (wb_name_i),
        .wb_data_i     (wb_data_i),
        .busy_cnt_o    (busy_cnt_o),
        .err_o         (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_reserve_i = 1'b0;
        wb_we_i      = 1'b0;
        wb_name_i    = 3'd0;
        wb_data_i    = 16'h0000;
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            rd_name_i = 3'(i);
            rs_name_i = 3'(7 - i);
            #1;
            checks++;
            if (rd_data_o !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rd_data[%0d]: got %h want 0000", i, rd_data_o);
            end
            checks++;
            if (rs_reserved_o !== 1'b0 || rd_reserved_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_reserved[%0d]: got rd=%b rs=%b want 0", i, rd_reserved_o, rs_reserved_o);
            end
        end
        checks++;
        if (busy_cnt_o !== 4'd0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0d err=%b want 0 0", busy_cnt_o, err_o);
        end
    endtask

    task automatic test_reserve_wb();
        rd_name_i = 3'd3; rd_reserve_i = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (rd_reserved_o !== 1'b1 || busy_cnt_o !== 4'd1) begin
            errors++;
            $display("FAIL rsv_r3: got rsv=%b busy=%0d want 1 1", rd_reserved_o, busy_cnt_o);
        end
        wb_we_i = 1'b1; wb_name_i = 3'd3; wb_data_i = 16'hBEEF;
        tick();
        idle();
        rs_name_i = 3'd3;
        #1;
        checks++;
        if (rs_data_o !== 16'hBEEF || rs_reserved_o !== 1'b0) begin
            errors++;
            $display("FAIL wb_r3: got data=%h rsv=%b want beef 0", rs_data_o, rs_reserved_o);
        end
        checks++;
        if (busy_cnt_o !== 4'd0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL wb_r3_cnt: got busy=%0d err=%b want 0 0", busy_cnt_o, err_o);
        end
    endtask

    task automatic test_same_edge();
        rd_name_i = 3'd5; rd_reserve_i = 1'b1;
        tick();
        wb_we_i = 1'b1; wb_name_i = 3'd5; wb_data_i = 16'h1234;
        tick();
        idle();
        rs_name_i = 3'd5;
        #1;
        checks++;
        if (rd_reserved_o !== 1'b1 || rs_data_o !== 16'h1234) begin
            errors++;
            $display("FAIL same_edge_r5: got rsv=%b data=%h want 1 1234", rd_reserved_o, rs_data_o);
        end
        checks++;
        if (busy_cnt_o !== 4'd1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_cnt: got busy=%0d err=%b want 1 0", busy_cnt_o, err_o);
        end
    endtask

    task automatic test_violations();
        pulse_reset();
        rd_name_i = 3'd2; rd_reserve_i = 1'b1;
        tick();
        tick();
        idle();
        #1;
        checks++;
        if (err_o !== 1'b1 || busy_cnt_o !== 4'd1 || rd_reserved_o !== 1'b1) begin
            errors++;
            $display("FAIL double_rsv: got err=%b busy=%0d rsv=%b want 1 1 1", err_o, busy_cnt_o, rd_reserved_o);
        end
        pulse_reset();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", err_o);
        end
        wb_we_i = 1'b1; wb_name_i = 3'd6; wb_data_i = 16'h6A6A;
        tick();
        idle();
        rs_name_i = 3'd6;
        #1;
        checks++;
        if (err_o !== 1'b1 || rs_data_o !== 16'h6A6A || busy_cnt_o !== 4'd0) begin
            errors++;
            $display("FAIL wb_unrsv: got err=%b data=%h busy=%0d want 1 6a6a 0", err_o, rs_data_o, busy_cnt_o);
        end
    endtask

    task automatic test_different_regs();
        pulse_reset();
        rd_name_i = 3'd1; rd_reserve_i = 1'b1;
        tick();
        rd_name_i = 3'd0;
        wb_we_i = 1'b1; wb_name_i = 3'd1; wb_data_i = 16'h0101;
        tick();
        idle();
        rd_name_i = 3'd0; rs_name_i = 3'd1;
        #1;
        checks++;
        if (rd_reserved_o !== 1'b1 || rs_reserved_o !== 1'b0 || rs_data_o !== 16'h0101) begin
            errors++;
            $display("FAIL diff_regs: got r0rsv=%b r1rsv=%b r1=%h want 1 0 0101", rd_reserved_o, rs_reserved_o, rs_data_o);
        end
        checks++;
        if (busy_cnt_o !== 4'd1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL diff_regs_cnt: got busy=%0d err=%b want 1 0", busy_cnt_o, err_o);
        end
    endtask

    task automatic test_full_and_reset();
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            rd_name_i = 3'(i); rd_reserve_i = 1'b1;
            tick();
        end
        idle();
        rd_name_i = 3'd7;
        #1;
        checks++;
        if (busy_cnt_o !== 4'd8 || err_o !== 1'b0 || rd_reserved_o !== 1'b1) begin
            errors++;
            $display("FAIL full: got busy=%0d err=%b rsv=%b want 8 0 1", busy_cnt_o, err_o, rd_reserved_o);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (busy_cnt_o !== 4'd0 || rd_reserved_o !== 1'b0 || rd_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst: got busy=%0d rsv=%b data=%h want 0 0 0000", busy_cnt_o, rd_reserved_o, rd_data_o);
        end
        rst = 1'b1;
        #1;
        wb_we_i = 1'b1; wb_name_i = 3'd7; wb_data_i = 16'h7777;
        tick();
        idle();
        #1;
        checks++;
        if (err_o !== 1'b1 || busy_cnt_o !== 4'd0) begin
            errors++;
            $display("FAIL wb_after_rst: got err=%b busy=%0d want 1 0", err_o, busy_cnt_o);
        end
    endtask

    task automatic test_bypass();
        pulse_reset();
        rd_name_i = 3'd4; rd_reserve_i = 1'b1;
        tick();
        idle();
        rs_name_i = 3'd4;
        wb_we_i = 1'b1; wb_name_i = 3'd4; wb_data_i = 16'hA5A5;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        checks++;
        if (rs_data_o !== 16'hA5A5 || rs_reserved_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same_cycle: got data=%h rsv=%b want a5a5 0", rs_data_o, rs_reserved_o);
        end
`else
        checks++;
        if (rs_data_o !== 16'h0000 || rs_reserved_o !== 1'b1) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got data=%h rsv=%b want 0000 1", rs_data_o, rs_reserved_o);
        end
`endif
        tick();
        idle();
        #1;
        checks++;
        if (rs_data_o !== 16'hA5A5 || rs_reserved_o !== 1'b0 || err_o !== 1'b0 || busy_cnt_o !== 4'd0) begin
            errors++;
            $display("FAIL bypass_next_cycle: got data=%h rsv=%b err=%b busy=%0d want a5a5 0 0 0", rs_data_o, rs_reserved_o, err_o, busy_cnt_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        rd_name_i = 3'd0;
        rs_name_i = 3'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        test_reset();
        tick();
        test_reserve_wb();
        test_same_edge();
        test_violations();
        test_different_regs();
        test_full_and_reset();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
